key_event_gen: RTL and testbench
================================

KEY_EVENT_GEN -- requirements
Module: key_event_gen

Interface
REQ-001 The module SHALL have parameter debounce_cycles_p, default 16, giving the consecutive stable cycles needed to accept a level change.
REQ-002 The module SHALL have parameter repeat_delay_p, default 32, giving the cycles from a press pulse to the first auto-repeat pulse.
REQ-003 The module SHALL have parameter repeat_rate_p, default 8, giving the cycles between later auto-repeat pulses.
REQ-004 Port clk_i, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port reset_n_i, input, 1: reset, asynchronous and active-low.
REQ-006 Ports left_i, right_i, rotate_i, start_i, input, 1 each: raw asynchronous button levels, active-high.
REQ-007 Ports left_o, right_o, rotate_o, start_o, output, 1 each: single-cycle event pulses, registered.
REQ-008 Port level_o, output, 4: debounced levels {start, rotate, right, left}, registered.

Function
REQ-009 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-010 Each key SHALL have its own debounce counter, sized $clog2(debounce_cycles_p+1) bits.
- The counter increments while the synchronized input differs from level_o.
- The counter clears to 0 on any cycle where they match.
REQ-011 When a debounce counter reaches debounce_cycles_p, the module SHALL invert that key's level_o bit on the next edge and clear the counter.
REQ-012 Latency from a raw edge held stable to the level_o change SHALL be exactly 2+debounce_cycles_p cycles; a glitch shorter than debounce_cycles_p synchronized cycles SHALL cause no change.
REQ-013 Each key SHALL run its own FSM with states IDLE, HELD and REPEAT.
REQ-014 IDLE->HELD on a level rise; the key's pulse output SHALL be asserted in the same cycle level_o first reads 1.
REQ-015 rotate and start SHALL stay in HELD until release and SHALL NOT auto-repeat.
REQ-016 left/right in HELD: a repeat counter counts from the press pulse.
- At repeat_delay_p cycles after the press pulse: emit a pulse and go to REPEAT.
- In REPEAT: emit a pulse every repeat_rate_p cycles.
REQ-017 Repeat counters SHALL be $clog2(max(repeat_delay_p,repeat_rate_p)+1) bits and SHALL NOT wrap while a key is held.
REQ-018 A level fall from any state SHALL return the key to IDLE and clear its repeat counter; no pulse is emitted on release.
REQ-019 Left/right conflict: while both left and right debounced levels are 1, left_o and right_o SHALL be 0.
- Both repeat counters are held at 0 during the conflict.
- A press of one key while the other is held SHALL NOT pulse.
- When the conflict ends, the remaining held key restarts its repeat_delay_p timing from 0.
REQ-020 If both left and right rise in the same cycle, neither SHALL pulse.
REQ-021 No output SHALL be high for two consecutive cycles, with one exception: repeat_rate_p=1 in REPEAT SHALL give a pulse every cycle.

Reset
REQ-022 Asserting reset_n_i low SHALL, asynchronously, set all of the following to 0:
- outputs;
- synchronizer flops;
- debounce and repeat counters;
- level_o;
- FSMs, to IDLE.
REQ-023 Reset asserted mid-hold SHALL cause no pulse at deassertion unless the key is re-accepted through full debounce (2+debounce_cycles_p cycles).
REQ-024 Reset deassertion SHALL be used only after external synchronization; no internal deassertion synchronizer is required.

Verification (debounce_cycles_p=4, repeat_delay_p=8, repeat_rate_p=3)
REQ-025 Rotate clean press:
- rotate_i high at cycle 0 -> level_o[2]=1 and rotate_o pulses exactly at cycle 6.
- Held 50 cycles -> no further pulse.
- Release -> level_o[2]=0 at release+6, no pulse.
REQ-026 Rotate glitch: rotate_i high for 3 cycles then low -> level_o and rotate_o remain 0 throughout.
REQ-027 Left auto-repeat: left_i held from cycle 0 -> left_o pulses at cycles 6, 14, 17, 20, 23 ... until release.
REQ-028 Left/right conflict:
- Left pressed at cycle 0 -> pulse at cycle 6.
- Right pressed at cycle 10 -> from cycle 16 no left/right pulses.
- Right released -> left pulses resume repeat_delay_p=8 cycles after right's level falls.
REQ-029 Reset mid-repeat:
- Left held, reset_n_i low at cycle 15 for 2 cycles -> all outputs 0 immediately.
- Left still held after reset -> next pulse at 6 cycles after deassertion.
REQ-030 Simultaneous presses:
- All four inputs rise in the same cycle -> rotate_o and start_o pulse at cycle 6; left_o and right_o stay 0.

Source files
------------

// File: rtl/key_event_gen.sv
`default_nettype none
// ============================================================================
//  Module   : key_event_gen
//  Purpose  : Turns four raw push-button levels (left, right, rotate, start)
//             into debounced levels and single-cycle key events.
//             left/right auto-repeat while held; rotate/start fire once per
//             press. Simultaneous left+right is treated as a conflict and
//             suppresses left/right events.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i      in   1  clock, rising edge
//    reset_n_i  in   1  asynchronous active-low reset (deassert synchronously
//                       outside this block)
//    left_i     in   1  raw button level, active-high, asynchronous
//    right_i    in   1  raw button level, active-high, asynchronous
//    rotate_i   in   1  raw button level, active-high, asynchronous
//    start_i    in   1  raw button level, active-high, asynchronous
//    left_o     out  1  registered single-cycle event pulse
//    right_o    out  1  registered single-cycle event pulse
//    rotate_o   out  1  registered single-cycle event pulse
//    start_o    out  1  registered single-cycle event pulse
//    level_o    out  4  registered debounced levels {start,rotate,right,left}
// ============================================================================
module key_event_gen #(
    parameter int debounce_cycles_p = 16,
    parameter int repeat_delay_p    = 32,
    parameter int repeat_rate_p     = 8
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    input  logic       left_i,
    input  logic       right_i,
    input  logic       rotate_i,
    input  logic       start_i,
    output logic       left_o,
    output logic       right_o,
    output logic       rotate_o,
    output logic       start_o,
    output logic [3:0] level_o
);

    localparam int deb_w   = $clog2(debounce_cycles_p + 1);
    localparam int rep_max = (repeat_delay_p > repeat_rate_p) ? repeat_delay_p : repeat_rate_p;
    localparam int rep_w   = $clog2(rep_max + 1);

    localparam logic [deb_w-1:0] deb_limit = deb_w'(debounce_cycles_p);
    localparam logic [rep_w-1:0] rep_delay = rep_w'(repeat_delay_p);
    localparam logic [rep_w-1:0] rep_rate  = rep_w'(repeat_rate_p);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } key_state_t;

    logic [3:0] raw;
    logic [3:0] sync_q1;
    logic [3:0] sync_q2;
    logic [3:0] flip;
    logic [3:0] level_next;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] pulse_q;
    logic       conflict_now;
    logic       conflict_next;
    logic       conflict_hold;

    assign raw = {start_i, rotate_i, right_i, left_i};

    // Two-flop synchronizer on every raw input.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sync_q1 <= 4'b0;
            sync_q2 <= 4'b0;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // Debounced levels toggle on the edge after a counter hits its limit.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            level_o <= 4'b0;
        end else begin
            level_o <= level_next;
        end
    end

    assign level_next = level_o ^ flip;
    assign rise       = flip & ~level_o;
    assign fall       = flip & level_o;

    // The conflict window covers both the cycle the second key's level rises
    // (so its press is suppressed) and the cycle the conflict ends (so the
    // surviving key restarts its repeat timing from zero at that edge).
    assign conflict_now  = level_o[0] & level_o[1];
    assign conflict_next = level_next[0] & level_next[1];
    assign conflict_hold = conflict_now | conflict_next;

    genvar k;
    generate
        for (k = 0; k < 4; k++) begin : g_key
            // Only left (0) and right (1) auto-repeat and take part in the conflict.
            localparam bit is_lr = (k < 2);

            logic [deb_w-1:0] deb_cnt;
            key_state_t       state_q;
            key_state_t       state_d;
            logic [rep_w-1:0] rcnt_q;
            logic [rep_w-1:0] rcnt_d;
            logic [rep_w-1:0] rcnt_inc;
            logic             pulse_d;

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == deb_limit) begin
                    deb_cnt <= '0;
                end else if (sync_q2[k] != level_o[k]) begin
                    deb_cnt <= deb_cnt + 1'b1;
                end else begin
                    deb_cnt <= '0;
                end
            end

            assign flip[k]  = (deb_cnt == deb_limit);
            assign rcnt_inc = rcnt_q + 1'b1;

            always_ff @(posedge clk_i or negedge reset_n_i) begin
                if (!reset_n_i) begin
                    state_q    <= IDLE;
                    rcnt_q     <= '0;
                    pulse_q[k] <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    rcnt_q     <= rcnt_d;
                    pulse_q[k] <= pulse_d;
                end
            end

            // rcnt_q holds the number of cycles since the last pulse (or since
            // the conflict ended), so a pulse is due when rcnt_q+1 reaches the
            // interval. It never wraps because it resets on every pulse.
            always_comb begin
                state_d = state_q;
                rcnt_d  = rcnt_q;
                pulse_d = 1'b0;
                case (state_q)
                    IDLE: begin
                        rcnt_d = '0;
                        if (rise[k]) begin
                            state_d = HELD;
                            pulse_d = !(is_lr && conflict_next);
                        end
                    end
                    HELD, REPEAT: begin
                        if (fall[k]) begin
                            state_d = IDLE;
                            rcnt_d  = '0;
                        end else if (is_lr && conflict_hold) begin
                            state_d = HELD;
                            rcnt_d  = '0;
                        end else if (is_lr) begin
                            if ((state_q == HELD && rcnt_inc == rep_delay) ||
                                (state_q == REPEAT && rcnt_inc == rep_rate)) begin
                                state_d = REPEAT;
                                rcnt_d  = '0;
                                pulse_d = 1'b1;
                            end else begin
                                rcnt_d = rcnt_inc;
                            end
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        rcnt_d  = '0;
                    end
                endcase
            end
        end
    endgenerate

    assign left_o   = pulse_q[0];
    assign right_o  = pulse_q[1];
    assign rotate_o = pulse_q[2];
    assign start_o  = pulse_q[3];

endmodule
`default_nettype wire

// File: tb/tb_key_event_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_event_gen
//  Purpose  : Directed self-checking bench for key_event_gen with
//             debounce=4, repeat delay=8, repeat rate=3.
//             Cycle index i is the rising edge that first samples the input
//             value driven just before it; outputs are checked 1 ns after it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_gen;

    logic       clk;
    logic       rst_n;
    logic       left_in;
    logic       right_in;
    logic       rotate_in;
    logic       start_in;
    logic       left_out;
    logic       right_out;
    logic       rotate_out;
    logic       start_out;
    logic [3:0] level;

    int checks = 0;
    int errors = 0;

    key_event_gen #(
        .debounce_cycles_p (4),
        .repeat_delay_p    (8),
        .repeat_rate_p     (3)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .left_i    (left_in),
        .right_i   (right_in),
        .rotate_i  (rotate_in),
        .start_i   (start_in),
        .left_o    (left_out),
        .right_o   (right_out),
        .rotate_o  (rotate_out),
        .start_o   (start_out),
        .level_o   (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp_lvl, input logic [3:0] exp_pls);
        logic [3:0] pls;
        pls = {start_out, rotate_out, right_out, left_out};
        checks++;
        assert ({level, pls} === {exp_lvl, exp_pls})
        else begin
            errors++;
            $error("FAIL %s level/pulses observed %b/%b expected %b/%b",
                   tag, level, pls, exp_lvl, exp_pls);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        left_in   = 1'b0;
        right_in  = 1'b0;
        rotate_in = 1'b0;
        start_in  = 1'b0;

        // Reset state
        repeat (3) step();
        chk("reset", 4'b0000, 4'b0000);
        rst_n = 1'b1;
        repeat (3) step();
        chk("idle", 4'b0000, 4'b0000);

        // Rotate clean press: held 56 sampled cycles, released afterwards
        for (int i = 0; i < 66; i++) begin
            rotate_in = (i < 56);
            step();
            chk($sformatf("rot_press c%0d", i),
                {1'b0, (i >= 6 && i < 62), 2'b00},
                {1'b0, (i == 6), 2'b00});
        end

        // Rotate glitch of 3 cycles
        for (int i = 0; i < 15; i++) begin
            rotate_in = (i < 3);
            step();
            chk($sformatf("rot_glitch c%0d", i), 4'b0000, 4'b0000);
        end

        // Left auto-repeat, released after 27 sampled cycles
        for (int i = 0; i < 41; i++) begin
            left_in = (i < 27);
            step();
            chk($sformatf("left_rep c%0d", i),
                {3'b000, (i >= 6 && i < 33)},
                {3'b000, (i == 6) || (i >= 14 && i < 33 && (i - 14) % 3 == 0)});
        end

        // Left/right conflict: right held 10..29, left held 0..61
        for (int i = 0; i < 73; i++) begin
            left_in  = (i < 62);
            right_in = (i >= 10 && i < 30);
            step();
            chk($sformatf("conflict c%0d", i),
                {2'b00, (i >= 16 && i < 36), (i >= 6 && i < 68)},
                {3'b000, (i == 6) || (i == 14) || (i >= 44 && i < 68 && (i - 44) % 3 == 0)});
        end

        // Reset mid-repeat
        for (int i = 0; i < 15; i++) begin
            left_in = 1'b1;
            step();
            chk($sformatf("pre_rst c%0d", i),
                {3'b000, (i >= 6)},
                {3'b000, (i == 6) || (i == 14)});
        end
        rst_n = 1'b0;
        #1;
        chk("rst_async", 4'b0000, 4'b0000);
        step();
        chk("rst_hold0", 4'b0000, 4'b0000);
        step();
        chk("rst_hold1", 4'b0000, 4'b0000);
        rst_n = 1'b1;
        for (int j = 0; j < 26; j++) begin
            left_in = (j < 12);
            step();
            chk($sformatf("post_rst c%0d", j),
                {3'b000, (j >= 6 && j < 18)},
                {3'b000, (j == 6) || (j == 14) || (j == 17)});
        end

        // All four pressed together, released after 13 sampled cycles
        for (int i = 0; i < 24; i++) begin
            left_in   = (i < 13);
            right_in  = (i < 13);
            rotate_in = (i < 13);
            start_in  = (i < 13);
            step();
            chk($sformatf("simul c%0d", i),
                (i >= 6 && i < 19) ? 4'b1111 : 4'b0000,
                (i == 6) ? 4'b1100 : 4'b0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
